// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode enum and flag layout for alu_64 and alu_arbiter
package alu_pkg;

   localparam int ALU_W    = 64;
   localparam int FUNCT_W  = 3;
   localparam int N_REQ    = 2;

   typedef enum logic [FUNCT_W-1:0] {
      ALU_LOAD = 3'd0,
      ALU_SUM  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_XOR  = 3'd4,
      ALU_NOT  = 3'd5,
      ALU_INC  = 3'd6
   } alu_funct_e;

   // Field order sets the packed bit order seen on resp_flags[5:0].
   typedef struct packed {
      logic overflow;
      logic negative;
      logic zero;
      logic equal;
      logic greater;
      logic less;
   } alu_flags_t;

endpackage

// File: rtl/alu_64.sv
// rtl/alu_64.sv - combinational 64-bit ALU; funct 3'b111 reports err with zero result/flags
import alu_pkg::*;

module alu_64 (
   input  logic [FUNCT_W-1:0] funct,
   input  logic [ALU_W-1:0]   a,
   input  logic [ALU_W-1:0]   b,
   output logic [ALU_W-1:0]   result,
   output alu_flags_t         flags,
   output logic               err
);

   logic [ALU_W-1:0] sum;
   logic [ALU_W-1:0] diff;
   logic [ALU_W-1:0] inc;
   logic             ovf;

   always_comb begin
      sum    = a + b;
      diff   = a - b;
      inc    = a + 64'd1;
      result = '0;
      ovf    = 1'b0;
      err    = 1'b0;
      case (funct)
         ALU_LOAD: result = a;
         ALU_SUM: begin
            result = sum;
            ovf    = (a[63] == b[63]) && (sum[63] != a[63]);
         end
         ALU_SUB: begin
            result = diff;
            ovf    = (a[63] != b[63]) && (diff[63] != a[63]);
         end
         ALU_AND:  result = a & b;
         ALU_XOR:  result = a ^ b;
         ALU_NOT:  result = ~a;
         ALU_INC: begin
            result = inc;
            ovf    = !a[63] && inc[63];
         end
         default:  err = 1'b1;
      endcase

      // Comparison flags are signed a-versus-b regardless of the operation.
      flags = '0;
      if (!err) begin
         flags.overflow = ovf;
         flags.negative = result[63];
         flags.zero     = (result == '0);
         flags.equal    = (a == b);
         flags.greater  = ($signed(a) > $signed(b));
         flags.less     = ($signed(a) < $signed(b));
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin share of one alu_64 between two requesters, 1-cycle registered response
// Optional ALU_ARB_BACKPRESSURE_EN adds resp_ready and holds the response until it is taken.
import alu_pkg::*;

module alu_arbiter (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ-1:0][FUNCT_W-1:0] req_funct,
   input  logic [N_REQ-1:0][ALU_W-1:0]   req_a,
   input  logic [N_REQ-1:0][ALU_W-1:0]   req_b,
   output logic                          resp_valid,
   output logic                          resp_id,
   output logic [ALU_W-1:0]              resp_result,
   output logic [5:0]                    resp_flags,
   output logic                          resp_err
`ifdef ALU_ARB_BACKPRESSURE_EN
   ,
   input  logic                          resp_ready
`endif
);

   logic             resp_valid_q, resp_valid_d;
   logic             resp_id_q,    resp_id_d;
   logic [ALU_W-1:0] resp_result_q, resp_result_d;
   alu_flags_t       resp_flags_q, resp_flags_d;
   logic             resp_err_q,   resp_err_d;
   logic             rr_last_q,    rr_last_d;

   logic             out_free;
   logic             grant_valid;
   logic             grant_id;
   logic             accept;
   logic [ALU_W-1:0] alu_result;
   alu_flags_t       alu_flags;
   logic             alu_err;

`ifdef ALU_ARB_BACKPRESSURE_EN
   assign out_free = !resp_valid_q || resp_ready;
`else
   assign out_free = 1'b1;
`endif

   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      case (req_valid)
         2'b01: begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
         end
         2'b10: begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
         end
         2'b11: begin
            grant_valid = 1'b1;
            grant_id    = !rr_last_q;
         end
         default: ;
      endcase
      accept    = grant_valid && out_free && !reset;
      req_ready = '0;
      if (accept) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   alu_64 u_alu (
      .funct  (req_funct[grant_id]),
      .a      (req_a[grant_id]),
      .b      (req_b[grant_id]),
      .result (alu_result),
      .flags  (alu_flags),
      .err    (alu_err)
   );

   // Without an accept a free output stage drains; otherwise the response is held.
   always_comb begin
      resp_valid_d  = resp_valid_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      resp_flags_d  = resp_flags_q;
      resp_err_d    = resp_err_q;
      rr_last_d     = rr_last_q;
      if (accept) begin
         resp_valid_d  = 1'b1;
         resp_id_d     = grant_id;
         resp_result_d = alu_result;
         resp_flags_d  = alu_flags;
         resp_err_d    = alu_err;
         rr_last_d     = grant_id;
      end else if (out_free) begin
         resp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_q  <= 1'b0;
         resp_id_q     <= 1'b0;
         resp_result_q <= '0;
         resp_flags_q  <= '0;
         resp_err_q    <= 1'b0;
         rr_last_q     <= 1'b1;
      end else begin
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_flags_q  <= resp_flags_d;
         resp_err_q    <= resp_err_d;
         rr_last_q     <= rr_last_d;
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_id     = resp_id_q;
   assign resp_result = resp_result_q;
   assign resp_flags  = resp_flags_q;
   assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized + directed bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        req_valid = '0;
   logic [1:0]        req_ready;
   logic [1:0][2:0]   req_funct = '0;
   logic [1:0][63:0]  req_a = '0;
   logic [1:0][63:0]  req_b = '0;
   logic              resp_valid;
   logic              resp_id;
   logic [63:0]       resp_result;
   logic [5:0]        resp_flags;
   logic              resp_err;
   logic              rdy = 1'b1;
   logic              rdy_eff;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_funct   (req_funct),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_valid  (resp_valid),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .resp_flags  (resp_flags),
      .resp_err    (resp_err)
`ifdef ALU_ARB_BACKPRESSURE_EN
      ,
      .resp_ready  (rdy)
`endif
   );

`ifdef ALU_ARB_BACKPRESSURE_EN
   assign rdy_eff = rdy;
`else
   assign rdy_eff = 1'b1;
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU: widen to 65-bit signed and test whether the true value fits.
   localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [64:0] SMIN = -65'sh0_8000_0000_0000_0000;

   task automatic model_alu(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] r, output logic [5:0] fl, output logic e);
      logic signed [64:0] wa, wb, w;
      logic ov;
      wa = $signed({a[63], a});
      wb = $signed({b[63], b});
      w  = '0;
      ov = 1'b0;
      e  = 1'b0;
      r  = '0;
      case (f)
         3'd0: r = a;
         3'd1: begin w = wa + wb; r = w[63:0]; ov = (w > SMAX) || (w < SMIN); end
         3'd2: begin w = wa - wb; r = w[63:0]; ov = (w > SMAX) || (w < SMIN); end
         3'd3: r = a & b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: begin w = wa + 65'sd1; r = w[63:0]; ov = (w > SMAX); end
         default: e = 1'b1;
      endcase
      if (e) fl = '0;
      else fl = {ov, r[63], r == 64'd0, a == b, $signed(a) > $signed(b), $signed(a) < $signed(b)};
   endtask

   // Model state mirrors what the DUT registers should hold at each falling edge.
   logic        live = 1'b0;
   logic        m_valid, m_id, m_err, m_rr;
   logic [63:0] m_result;
   logic [5:0]  m_flags;

   always @(negedge clk) begin
      logic free, gv, eid, e;
      logic [1:0] exp_rdy;
      logic [63:0] r;
      logic [5:0] fl;
      if (live) begin
         check("resp_valid", {63'd0, resp_valid}, {63'd0, m_valid});
         if (m_valid) begin
            check("resp_id", {63'd0, resp_id}, {63'd0, m_id});
            check("resp_result", resp_result, m_result);
            check("resp_flags", {58'd0, resp_flags}, {58'd0, m_flags});
            check("resp_err", {63'd0, resp_err}, {63'd0, m_err});
         end
      end
      free    = !m_valid || rdy_eff;
      eid     = (req_valid == 2'b11) ? !m_rr : req_valid[1];
      gv      = (req_valid != 2'b00) && free && !reset;
      exp_rdy = gv ? (eid ? 2'b10 : 2'b01) : 2'b00;
      if (live) check("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
      if (reset) begin
         m_valid = 0; m_id = 0; m_result = 0; m_flags = 0; m_err = 0; m_rr = 1; live = 1;
      end else if (gv) begin
         model_alu(req_funct[eid], req_a[eid], req_b[eid], r, fl, e);
         m_valid = 1; m_id = eid; m_result = r; m_flags = fl; m_err = e; m_rr = eid;
      end else if (free) begin
         m_valid = 0;
      end
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      req_valid = '0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   function automatic logic [63:0] rand64;
      case ($urandom_range(0, 6))
         0: rand64 = 64'd0;
         1: rand64 = '1;
         2: rand64 = 64'h7FFF_FFFF_FFFF_FFFF;
         3: rand64 = 64'h8000_0000_0000_0000;
         4: rand64 = {60'd0, 4'($urandom_range(0, 15))};
         default: rand64 = {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [63:0] r;
      logic [5:0]  fl;
      logic        e;

      model_alu(3'd1, 64'd12, 64'd25, r, fl, e);
      check("model_sum", r, 64'd37);
      check("model_sum_flags", {58'd0, fl}, 64'b000001);
      model_alu(3'd6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, r, fl, e);
      check("model_inc_ovf", {58'd0, fl}, 64'b110010);

      do_reset();
      @(negedge clk);
      check("rst_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_result", resp_result, 64'd0);
      check("rst_flags", {58'd0, resp_flags}, 64'd0);
      check("rst_id_err", {62'd0, resp_id, resp_err}, 64'd0);

      // Single SUM from requester 0
      cyc();
      req_valid = 2'b01; req_funct[0] = 3'd1; req_a[0] = 64'd12; req_b[0] = 64'd25;
      @(negedge clk);
      check("sum_ready", {62'd0, req_ready}, 64'b01);
      cyc();
      req_valid = 2'b00;
      @(negedge clk);
      check("sum_valid", {63'd0, resp_valid}, 64'd1);
      check("sum_id", {63'd0, resp_id}, 64'd0);
      check("sum_result", resp_result, 64'd37);
      check("sum_flags", {58'd0, resp_flags}, 64'b000001);

      // Alternating grants on a continuous tie
      do_reset();
      req_valid = 2'b11;
      req_funct[0] = 3'd2; req_a[0] = 64'd54; req_b[0] = 64'd54;
      req_funct[1] = 3'd4; req_a[1] = 64'd12; req_b[1] = 64'd25;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k < 4) check("rr_ready", {62'd0, req_ready}, (k % 2) ? 64'b10 : 64'b01);
         if (k > 0) begin
            check("rr_id", {63'd0, resp_id}, 64'((k - 1) % 2));
            check("rr_result", resp_result, ((k - 1) % 2) ? 64'd21 : 64'd0);
            check("rr_flags", {58'd0, resp_flags}, ((k - 1) % 2) ? 64'b000001 : 64'b001100);
         end
         cyc();
         if (k == 3) req_valid = 2'b00;
      end

      // Signed overflow from requester 1
      req_valid = 2'b10; req_funct[1] = 3'd1;
      req_a[1] = 64'h7FFF_FFFF_FFFF_FFFF; req_b[1] = 64'd3;
      cyc();
      req_valid = 2'b00;
      @(negedge clk);
      check("ovf_result", resp_result, 64'h8000_0000_0000_0002);
      check("ovf_flags", {58'd0, resp_flags}, 64'b110010);
      check("ovf_id", {63'd0, resp_id}, 64'd1);

      // Unsupported funct
      cyc();
      req_valid = 2'b01; req_funct[0] = 3'd7; req_a[0] = 64'd5; req_b[0] = 64'd5;
      cyc();
      req_valid = 2'b00;
      @(negedge clk);
      check("err_flag", {63'd0, resp_err}, 64'd1);
      check("err_result", resp_result, 64'd0);
      check("err_flags", {58'd0, resp_flags}, 64'd0);

      // Reset right after an accept discards the response and restores the tie order
      cyc();
      req_valid = 2'b01; req_funct[0] = 3'd1; req_a[0] = 64'd1; req_b[0] = 64'd2;
      cyc();
      reset = 1'b1; req_valid = 2'b11;
      @(negedge clk);
      check("rstmid_ready", {62'd0, req_ready}, 64'd0);
      check("rstmid_pending", {63'd0, resp_valid}, 64'd1);
      cyc();
      reset = 1'b0;
      @(negedge clk);
      check("rstmid_valid", {63'd0, resp_valid}, 64'd0);
      check("rstmid_result", resp_result, 64'd0);
      check("rstmid_tie", {62'd0, req_ready}, 64'b01);
      cyc();
      req_valid = 2'b00;

`ifdef ALU_ARB_BACKPRESSURE_EN
      // Held response under backpressure, then drain plus new accept together
      cyc();
      rdy = 1'b0;
      req_valid = 2'b01; req_funct[0] = 3'd1; req_a[0] = 64'd12; req_b[0] = 64'd25;
      cyc();
      req_valid = 2'b10; req_funct[1] = 3'd4; req_a[1] = 64'd12; req_b[1] = 64'd25;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_hold_ready", {62'd0, req_ready}, 64'd0);
         check("bp_hold_result", resp_result, 64'd37);
         cyc();
      end
      rdy = 1'b1;
      @(negedge clk);
      check("bp_drain_ready", {62'd0, req_ready}, 64'b10);
      cyc();
      req_valid = 2'b00;
      @(negedge clk);
      check("bp_new_result", resp_result, 64'd21);
      check("bp_new_id", {63'd0, resp_id}, 64'd1);
`endif

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc();
         reset     = ($urandom_range(0, 199) == 0);
         req_valid = 2'($urandom_range(0, 3));
         rdy       = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 2; i++) begin
            req_funct[i] = 3'($urandom_range(0, 7));
            req_a[i]     = rand64();
            req_b[i]     = rand64();
         end
      end
      cyc();
      reset = 1'b0;
      req_valid = 2'b00;
      cyc();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
